count_cmd_controller: RTL and testbench

//  Parametrised successor of the single-bit start/stop count controller. Decodes opcode+argument

---
 rtl/count_cmd_pkg.sv | 33 +++
 rtl/window_timer.sv | 33 +++
 rtl/count_cmd_controller.sv | 160 ++++++++++++++++
 tb/tb_count_cmd_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/count_cmd_pkg.sv
// Shared definitions for the count command controller: default sizes,
// opcode values and the controller state encoding.
package count_cmd_pkg;

  // Default sizing of the controller and its window timer.
  localparam int CMD_W_DEF     = 16;
  localparam int OP_W_DEF      = 4;
  localparam int NUM_CH_DEF    = 4;
  localparam int WIN_SHIFT_DEF = 10;

  // Opcode values carried in the top OP_W bits of a command word.
  localparam int unsigned OP_LEGACY     = 0;
  localparam int unsigned OP_SET_MASK   = 1;
  localparam int unsigned OP_SET_WIN    = 2;
  localparam int unsigned OP_START_TIM  = 3;
  localparam int unsigned OP_START_CONT = 4;
  localparam int unsigned OP_STOP       = 5;
  localparam int unsigned OP_CLEAR      = 6;

  // Controller states; DONE is the single latch cycle after a timed window.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN_CONT  = 2'd1,
    ST_RUN_TIMED = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Timer width: wide enough for the largest argument shifted by WIN_SHIFT.
  function automatic int timer_width(input int cmd_w, input int op_w, input int win_shift);
    return cmd_w - op_w + win_shift;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Load/enable down-counter for the timed counting window. expire_o is high
// during the last enabled cycle of the window, so the FSM can leave the run
// state on the same edge the count reaches zero.
module window_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Last cycle of the window: enabled and one tick remaining.
  always_comb begin
    expire_o = en_i && !load_i && (count_q == W'(1));
  end

endmodule

// File: rtl/count_cmd_controller.sv
// Command decoder and run-state controller sitting between the SPI slave and
// the channel counters.
//
// Handshake: CMD_VALID is a one-cycle strobe with no back-pressure. COMMAND
// is sampled only on a rising edge where CMD_VALID=1; every strobed word is
// either executed or dropped with CMD_ERR set. All outputs are registered and
// reflect an accepted command in the cycle after the accepting edge.
module count_cmd_controller
  import count_cmd_pkg::*;
#(
  parameter int CMD_W     = CMD_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int WIN_SHIFT = WIN_SHIFT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CMD_VALID,
  input  logic [CMD_W-1:0]  COMMAND,
  output logic [NUM_CH-1:0] START_COUNT,
  output logic              CLEAR_COUNT,
  output logic              LATCH,
  output logic              BUSY,
  output logic              CMD_ERR,
  output state_e            STATE_DBG
);

  localparam int ARG_W = CMD_W - OP_W;
  localparam int TIM_W = timer_width(CMD_W, OP_W, WIN_SHIFT);

  logic [OP_W-1:0]   op;
  logic [ARG_W-1:0]  arg;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [ARG_W-1:0]  win_q, win_d;
  logic              err_d, clear_d;
  logic [NUM_CH-1:0] start_count_q;
  logic              clear_q, latch_q, busy_q, err_q;

  logic              idle_like, running;
  logic              tim_load, tim_en, tim_expire;
  logic [TIM_W-1:0]  tim_load_val;

  assign op  = COMMAND[CMD_W-1 -: OP_W];
  assign arg = COMMAND[ARG_W-1:0];

  assign tim_load_val = TIM_W'(win_q) << WIN_SHIFT;
  assign tim_en       = (state_q == ST_RUN_TIMED);

  window_timer #(
    .W (TIM_W)
  ) u_window_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tim_load),
    .en_i       (tim_en),
    .load_val_i (tim_load_val),
    .expire_o   (tim_expire)
  );

  // Next-state decode: window expiry first, then the strobed command, so a
  // STOP on the expiry cycle overrides the move to DONE.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    win_d     = win_q;
    err_d     = err_q;
    clear_d   = 1'b0;
    tim_load  = 1'b0;
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    running   = (state_q == ST_RUN_CONT) || (state_q == ST_RUN_TIMED);

    if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
    if ((state_q == ST_RUN_TIMED) && tim_expire) begin
      state_d = ST_DONE;
    end

    if (CMD_VALID) begin
      case (op)
        OP_W'(OP_LEGACY): begin
          if (arg == ARG_W'(0)) begin
            if (running) state_d = ST_IDLE;
          end else if ((arg == ARG_W'(1)) && idle_like) begin
            mask_d  = '1;
            state_d = ST_RUN_CONT;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_W'(OP_SET_MASK): begin
          if (idle_like) mask_d = arg[NUM_CH-1:0];
          else           err_d  = 1'b1;
        end
        OP_W'(OP_SET_WIN): begin
          if (idle_like && (arg != '0)) win_d = arg;
          else                          err_d = 1'b1;
        end
        OP_W'(OP_START_TIM): begin
          if (idle_like && (mask_q != '0)) begin
            state_d  = ST_RUN_TIMED;
            tim_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_W'(OP_START_CONT): begin
          if (idle_like && (mask_q != '0)) state_d = ST_RUN_CONT;
          else                             err_d   = 1'b1;
        end
        OP_W'(OP_STOP): begin
          if (running) state_d = ST_IDLE;
        end
        OP_W'(OP_CLEAR): begin
          if (idle_like) begin
            clear_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State, configuration and output registers; outputs are decoded from the
  // next state so they change exactly one cycle after an accepted command.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      mask_q        <= '1;
      win_q         <= ARG_W'(1);
      start_count_q <= '0;
      clear_q       <= 1'b0;
      latch_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      win_q         <= win_d;
      start_count_q <= ((state_d == ST_RUN_CONT) || (state_d == ST_RUN_TIMED)) ? mask_d : '0;
      clear_q       <= clear_d;
      latch_q       <= (state_d == ST_DONE);
      busy_q        <= (state_d == ST_RUN_CONT) || (state_d == ST_RUN_TIMED);
      err_q         <= err_d;
    end
  end

  assign START_COUNT = start_count_q;
  assign CLEAR_COUNT = clear_q;
  assign LATCH       = latch_q;
  assign BUSY        = busy_q;
  assign CMD_ERR     = err_q;
  assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_count_cmd_controller.sv
// Directed bench for count_cmd_controller with NUM_CH=4, WIN_SHIFT=2.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_count_cmd_controller;
  import count_cmd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] command;
  logic [3:0]  start_count;
  logic        clear_count;
  logic        latch;
  logic        busy;
  logic        cmd_err;
  state_e      state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;

  count_cmd_controller #(
    .CMD_W     (16),
    .OP_W      (4),
    .NUM_CH    (4),
    .WIN_SHIFT (2)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .CMD_VALID   (cmd_valid),
    .COMMAND     (command),
    .START_COUNT (start_count),
    .CLEAR_COUNT (clear_count),
    .LATCH       (latch),
    .BUSY        (busy),
    .CMD_ERR     (cmd_err),
    .STATE_DBG   (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one command for one cycle; called and returns on a falling edge.
  task automatic send(input logic [15:0] cmd);
    cmd_valid = 1'b1;
    command   = cmd;
    @(negedge clk);
    cmd_valid = 1'b0;
    command   = 16'h0000;
  endtask

  // Count consecutive cycles with START_COUNT equal to pattern (bounded).
  task automatic count_run(input logic [3:0] pattern, output int n);
    n = 0;
    while ((start_count == pattern) && (n < 200)) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    command   = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_start", start_count, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_latch", latch, 1'b0);
    check("rst_clear", clear_count, 1'b0);
    check("rst_err", cmd_err, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Legacy start / stop
    send(16'h0001);
    check("leg_start", start_count, 4'hF);
    check("leg_busy", busy, 1'b1);
    send(16'h0000);
    check("leg_stop", start_count, 4'h0);
    check("leg_stop_busy", busy, 1'b0);
    check("leg_stop_latch", latch, 1'b0);

    // 2. Timed window: mask 5, window 3 -> 12 cycles, then LATCH
    send(16'h1005);
    send(16'h2003);
    send(16'h3000);
    check("tim_busy", busy, 1'b1);
    count_run(4'h5, cnt);
    check("tim_len", cnt, 12);
    check("tim_latch", latch, 1'b1);
    check("tim_done_start", start_count, 4'h0);
    check("tim_done_busy", busy, 1'b0);
    @(negedge clk);
    check("tim_latch_off", latch, 1'b0);
    check("tim_idle", state_dbg, ST_IDLE);

    // 3. STOP on the final timed cycle, then STOP mid-window
    send(16'h3000);
    repeat (11) @(negedge clk);
    check("stop12_pre", start_count, 4'h5);
    send(16'h5000);
    check("stop12_start", start_count, 4'h0);
    check("stop12_latch", latch, 1'b0);
    check("stop12_state", state_dbg, ST_IDLE);
    @(negedge clk);
    check("stop12_latch2", latch, 1'b0);
    send(16'h3000);
    repeat (5) @(negedge clk);
    send(16'h5000);
    check("abort_start", start_count, 4'h0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("abort_nolatch", latch, 1'b0);
      @(negedge clk);
    end

    // 4. Error cases and CLEAR
    send(16'h0001);
    send(16'h4000);
    check("err_restart", cmd_err, 1'b1);
    check("err_restart_start", start_count, 4'hF);
    check("err_restart_busy", busy, 1'b1);
    send(16'h1003);
    check("err_mask_run", start_count, 4'hF);
    send(16'h0000);
    check("err_stop", busy, 1'b0);
    send(16'h6000);
    check("clr_pulse", clear_count, 1'b1);
    check("clr_err", cmd_err, 1'b0);
    @(negedge clk);
    check("clr_pulse_end", clear_count, 1'b0);
    send(16'h2000);
    check("err_win0", cmd_err, 1'b1);
    check("err_win0_state", state_dbg, ST_IDLE);
    send(16'h6000);
    send(16'hF000);
    check("err_badop", cmd_err, 1'b1);
    check("err_badop_start", start_count, 4'h0);
    send(16'h6000);
    send(16'h0002);
    check("err_legarg", cmd_err, 1'b1);
    send(16'h6000);
    send(16'h1000);
    send(16'h4000);
    check("err_mask0", cmd_err, 1'b1);
    check("err_mask0_busy", busy, 1'b0);
    send(16'h6000);
    check("clr_final", cmd_err, 1'b0);

    // 5. Reset mid-window, then defaults restored (mask F, window 1)
    send(16'h1003);
    send(16'h2005);
    send(16'h3000);
    repeat (3) @(negedge clk);
    check("pre_rst_start", start_count, 4'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_start", start_count, 4'h0);
    check("async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_latch", latch, 1'b0);
    @(negedge clk);
    check("post_rst_latch2", latch, 1'b0);
    check("post_rst_state", state_dbg, ST_IDLE);
    send(16'h3000);
    count_run(4'hF, cnt);
    check("dflt_len", cnt, 4);
    check("dflt_latch", latch, 1'b1);
    // A command in the DONE cycle is handled as in IDLE
    send(16'h4000);
    check("done_cmd_start", start_count, 4'hF);
    check("done_cmd_latch", latch, 1'b0);
    check("done_cmd_err", cmd_err, 1'b0);
    send(16'h5000);
    check("done_cmd_stop", start_count, 4'h0);

    // 6. COMMAND held without CMD_VALID
    command = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("novalid_start", start_count, 4'h0);
      check("novalid_busy", busy, 1'b0);
    end
    command = 16'h0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
